// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } btn_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;    // 10 ms at 25 MHz
    localparam int DEFAULT_LONG_CYCLES     = 25000000;  // 1 s at 25 MHz

    // Bits needed to hold values 0..cycles without wrapping.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM and optional long-press
// counter (built only when BTN_LONG_PRESS_EN is defined).
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic res,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_toggle,
    output logic btn_long
);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_params
        $error("btn_channel: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
    end

    localparam int            DW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          sync;
    btn_state_t    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          toggle_q, toggle_d;

    assign sync = sync_q[1];

    // NOTE: every register here uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_in};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!sync) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d  = PRESSED;
                    level_d  = 1'b1;
                    press_d  = 1'b1;
                    toggle_d = ~toggle_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end
            end
            DEB_RELEASE: begin
                if (sync) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_toggle  = toggle_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int            LW       = cnt_width(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

    logic [LW-1:0] long_cnt_q;
    logic          long_q;
    logic          holding;

    assign holding = (state_q == PRESSED) || (state_q == DEB_RELEASE);

    // Counter is zero on the press edge, so it reaches LONG_CYCLES that many edges later.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_q <= holding && !release_d && (long_cnt_q == LONG_MAX - 1'b1);
            if (press_d || release_d) begin
                long_cnt_q <= '0;
            end else if (holding && long_cnt_q != LONG_MAX) begin
                long_cnt_q <= long_cnt_q + 1'b1;
            end
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: polarity normalisation and one btn_channel per pin.
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_toggle,
    output logic [N_BTN-1:0] btn_long
);

    logic [N_BTN-1:0] btn_norm;

    // Inside the design 1 always means pressed.
    assign btn_norm = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .clk         (clk),
            .res         (res),
            .btn_in      (btn_norm[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_toggle  (btn_toggle[i]),
            .btn_long    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=8, LONG_CYCLES=32, active-low pins.
module tb_btn_conditioner;

    localparam int N   = 2;
    localparam int DEB = 8;
    localparam int LNG = 32;
    // Raw change driven before edge 0 -> output visible at the negedge after edge DEB+2.
    localparam int LAT = DEB + 3;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic [N-1:0] btn_raw = 2'b11;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_toggle, btn_long;

    int tests = 0;
    int fails = 0;

    int press_cnt[N], press_at[N], rel_cnt[N], rel_at[N], long_cnt[N], long_at[N];

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .res         (res),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle),
        .btn_long    (btn_long)
    );

    // Advance n negedges, recording pulse counts and first-seen index (1-based) per channel.
    task automatic step(input int n);
        for (int c = 0; c < N; c++) begin
            press_cnt[c] = 0; press_at[c] = -1;
            rel_cnt[c]   = 0; rel_at[c]   = -1;
            long_cnt[c]  = 0; long_at[c]  = -1;
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if (btn_press[c])   begin press_cnt[c]++; if (press_at[c] < 0) press_at[c] = k; end
                if (btn_release[c]) begin rel_cnt[c]++;   if (rel_at[c] < 0)   rel_at[c]   = k; end
                if (btn_long[c])    begin long_cnt[c]++;  if (long_at[c] < 0)  long_at[c]  = k; end
            end
        end
    endtask

    task automatic do_reset();
        res = 1'b0;
        btn_raw = 2'b11;
        step(3);
        res = 1'b1;
        step(3);
    endtask

    task automatic test_reset();
        res = 1'b0;
        btn_raw = 2'b00;
        step(4);
        tests++;
        if ({btn_level, btn_press, btn_release, btn_toggle, btn_long} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {btn_level, btn_press, btn_release, btn_toggle, btn_long});
        end
        res = 1'b1;
        step(20);
        for (int c = 0; c < N; c++) begin
            tests++;
            if (press_at[c] !== LAT) begin
                fails++; $display("FAIL reset_held_press_at ch%0d: got %0d, want %0d", c, press_at[c], LAT);
            end
            tests++;
            if (press_cnt[c] !== 1) begin
                fails++; $display("FAIL reset_held_press_cnt ch%0d: got %0d, want 1", c, press_cnt[c]);
            end
        end
        tests++;
        if (btn_level !== 2'b11) begin
            fails++; $display("FAIL reset_held_level: got %b, want 11", btn_level);
        end
    endtask

    task automatic test_press();
        do_reset();
        btn_raw[0] = 1'b0;
        step(20);
        tests++;
        if (press_at[0] !== LAT || press_cnt[0] !== 1) begin
            fails++; $display("FAIL press_pulse: at %0d cnt %0d, want at %0d cnt 1", press_at[0], press_cnt[0], LAT);
        end
        tests++;
        if (btn_level !== 2'b01 || btn_toggle !== 2'b01) begin
            fails++; $display("FAIL press_level_toggle: level %b toggle %b, want 01 01", btn_level, btn_toggle);
        end
        tests++;
        if (press_cnt[1] !== 0 || rel_cnt[0] !== 0) begin
            fails++; $display("FAIL press_isolation: ch1 press %0d ch0 rel %0d, want 0 0", press_cnt[1], rel_cnt[0]);
        end
    endtask

    task automatic test_bounce();
        int total;
        do_reset();
        btn_raw[0] = 1'b0; step(5); total = press_cnt[0];
        btn_raw[0] = 1'b1; step(1); total += press_cnt[0];
        tests++;
        if (total !== 0) begin
            fails++; $display("FAIL bounce_early: got %0d pulses, want 0", total);
        end
        btn_raw[0] = 1'b0;
        step(12);
        tests++;
        if (press_at[0] !== LAT || press_cnt[0] !== 1) begin
            fails++; $display("FAIL bounce_press: at %0d cnt %0d, want at %0d cnt 1", press_at[0], press_cnt[0], LAT);
        end
        step(8);
        tests++;
        if (press_cnt[0] !== 0 || btn_level[0] !== 1'b1) begin
            fails++; $display("FAIL bounce_after: extra %0d level %b, want 0 1", press_cnt[0], btn_level[0]);
        end
    endtask

    task automatic test_release();
        btn_raw[0] = 1'b1;
        step(20);
        tests++;
        if (rel_at[0] !== LAT || rel_cnt[0] !== 1) begin
            fails++; $display("FAIL release_pulse: at %0d cnt %0d, want at %0d cnt 1", rel_at[0], rel_cnt[0], LAT);
        end
        tests++;
        if (btn_level[0] !== 1'b0 || btn_toggle[0] !== 1'b1 || press_cnt[0] !== 0) begin
            fails++; $display("FAIL release_state: level %b toggle %b press %0d, want 0 1 0",
                              btn_level[0], btn_toggle[0], press_cnt[0]);
        end
        btn_raw[0] = 1'b0;
        step(20);
        tests++;
        if (press_at[0] !== LAT || btn_toggle[0] !== 1'b0) begin
            fails++; $display("FAIL second_press: at %0d toggle %b, want %0d 0", press_at[0], btn_toggle[0], LAT);
        end
        btn_raw[0] = 1'b1;
        step(20);
        tests++;
        if (rel_cnt[0] !== 1 || btn_toggle[0] !== 1'b0) begin
            fails++; $display("FAIL second_release: rel %0d toggle %b, want 1 0", rel_cnt[0], btn_toggle[0]);
        end
    endtask

    task automatic test_long();
        do_reset();
        btn_raw[0] = 1'b0;
        step(LAT + 60);
`ifdef BTN_LONG_PRESS_EN
        tests++;
        if (long_at[0] !== LAT + LNG || long_cnt[0] !== 1) begin
            fails++; $display("FAIL long_pulse: at %0d cnt %0d, want at %0d cnt 1", long_at[0], long_cnt[0], LAT + LNG);
        end
`else
        tests++;
        if (long_cnt[0] !== 0) begin
            fails++; $display("FAIL long_disabled: got %0d pulses, want 0", long_cnt[0]);
        end
`endif
        tests++;
        if (long_cnt[1] !== 0) begin
            fails++; $display("FAIL long_other_ch: got %0d pulses, want 0", long_cnt[1]);
        end
        btn_raw[0] = 1'b1;
        step(20);
        tests++;
        if (rel_at[0] !== LAT || long_cnt[0] !== 0) begin
            fails++; $display("FAIL long_release: rel at %0d long %0d, want %0d 0", rel_at[0], long_cnt[0], LAT);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        btn_raw[0] = 1'b0;
        step(3);
        btn_raw[1] = 1'b0;
        step(20);
        tests++;
        if (press_at[0] !== LAT - 3 || press_at[1] !== LAT) begin
            fails++; $display("FAIL independent_press: ch0 at %0d ch1 at %0d, want %0d %0d",
                              press_at[0], press_at[1], LAT - 3, LAT);
        end
        btn_raw = 2'b11;
        step(20);
        tests++;
        if (rel_at[0] !== LAT || rel_at[1] !== LAT || btn_toggle !== 2'b11) begin
            fails++; $display("FAIL independent_release: at %0d %0d toggle %b, want %0d %0d 11",
                              rel_at[0], rel_at[1], btn_toggle, LAT, LAT);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn_raw[0] = 1'b0;
        step(6);
        res = 1'b0;
        step(3);
        tests++;
        if (press_cnt[0] !== 0 || btn_level[0] !== 1'b0 || btn_toggle[0] !== 1'b0) begin
            fails++; $display("FAIL reset_mid_debounce: press %0d level %b toggle %b, want 0 0 0",
                              press_cnt[0], btn_level[0], btn_toggle[0]);
        end
        res = 1'b1;
        step(20);
        tests++;
        if (press_at[0] !== LAT || btn_toggle[0] !== 1'b1) begin
            fails++; $display("FAIL reset_mid_restart: at %0d toggle %b, want %0d 1", press_at[0], btn_toggle[0], LAT);
        end
        res = 1'b0;
        step(3);
        tests++;
        if (btn_toggle !== 2'b00 || btn_level !== 2'b00 || rel_cnt[0] !== 0) begin
            fails++; $display("FAIL reset_mid_hold: toggle %b level %b rel %0d, want 00 00 0",
                              btn_toggle, btn_level, rel_cnt[0]);
        end
        res = 1'b1;
        step(20);
        tests++;
        if (press_at[0] !== LAT || press_cnt[0] !== 1) begin
            fails++; $display("FAIL reset_hold_restart: at %0d cnt %0d, want %0d 1", press_at[0], press_cnt[0], LAT);
        end
        btn_raw[0] = 1'b1;
        step(20);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_long();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
